// File: rtl/cp0_exception_unit.sv
// CP0 exception unit: holds the MIPS coprocessor-0 registers that exception
// handling needs. It services MFC0/MTC0 accesses, prioritises exceptions from
// the MEM stage, and produces the flush and PC-redirect controls.
module cp0_exception_unit #(
    parameter logic [31:0] EXC_VECTOR = 32'hBFC0_0380
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MEM_Valid,
    input  logic [8:0]  MEM_ExceptType,
    input  logic [31:0] MEM_PC,
    input  logic [31:0] MEM_ALUOut,
    input  logic        MEM_IsInDelaySlot,
    input  logic [5:0]  Ext_Int,
    input  logic [4:0]  CP0_RdAddr,
    input  logic [2:0]  CP0_RdSel,
    output logic [31:0] CP0_RdData,
    input  logic        CP0Wr,
    input  logic [4:0]  CP0_WrAddr,
    input  logic [2:0]  CP0_WrSel,
    input  logic [31:0] CP0_WrData,
    output logic        Exc_Flush,
    output logic        Exc_Redirect,
    output logic [31:0] Exc_NPC,
    output logic        Int_Pending
);

    localparam logic [4:0] ADDR_BADVADDR = 5'd8;
    localparam logic [4:0] ADDR_COUNT    = 5'd9;
    localparam logic [4:0] ADDR_COMPARE  = 5'd11;
    localparam logic [4:0] ADDR_STATUS   = 5'd12;
    localparam logic [4:0] ADDR_CAUSE    = 5'd13;
    localparam logic [4:0] ADDR_EPC      = 5'd14;

    logic [31:0] count_q, compare_q, epc_q, badvaddr_q;
    logic [7:0]  im_q;
    logic        exl_q, ie_q;
    logic        bd_q, ti_q, toggle_q;
    logic [5:0]  ip_hw_q;
    logic [1:0]  ip_sw_q;
    logic [4:0]  exc_code_q;

    logic [31:0] status_val, cause_val, epc_fwd;
    logic        wr_sel0, wr_count, wr_compare, wr_status, wr_cause, wr_epc;
    logic        int_pending_raw;
    logic        exc_take, eret_take, bad_from_pc, bad_from_alu;
    logic [4:0]  exc_code;

    // The timer interrupt shares the IP7 position with hardware line 5.
    assign status_val = {9'b0, 1'b1, 6'b0, im_q, 6'b0, exl_q, ie_q};
    assign cause_val  = {bd_q, ti_q, 14'b0, ip_hw_q[5] | ti_q, ip_hw_q[4:0],
                         ip_sw_q, 1'b0, exc_code_q, 2'b0};

    assign wr_sel0    = CP0Wr & (CP0_WrSel == 3'd0);
    assign wr_count   = wr_sel0 & (CP0_WrAddr == ADDR_COUNT);
    assign wr_compare = wr_sel0 & (CP0_WrAddr == ADDR_COMPARE);
    assign wr_status  = wr_sel0 & (CP0_WrAddr == ADDR_STATUS);
    assign wr_cause   = wr_sel0 & (CP0_WrAddr == ADDR_CAUSE);
    assign wr_epc     = wr_sel0 & (CP0_WrAddr == ADDR_EPC);

    // An ERET issued alongside an MTC0 to EPC must return to the new value.
    assign epc_fwd = wr_epc ? CP0_WrData : epc_q;

    assign int_pending_raw = (|(cause_val[15:8] & im_q)) & ie_q & ~exl_q;
    assign Int_Pending     = rst & int_pending_raw;

    // MFC0 read mux, straight from the current register contents.
    always_comb begin
        CP0_RdData = 32'h0;
        if (CP0_RdSel == 3'd0) begin
            case (CP0_RdAddr)
                ADDR_BADVADDR: CP0_RdData = badvaddr_q;
                ADDR_COUNT:    CP0_RdData = count_q;
                ADDR_COMPARE:  CP0_RdData = compare_q;
                ADDR_STATUS:   CP0_RdData = status_val;
                ADDR_CAUSE:    CP0_RdData = cause_val;
                ADDR_EPC:      CP0_RdData = epc_q;
                default:       CP0_RdData = 32'h0;
            endcase
        end
    end

    // Priority encoder picking the one exception to take from the MEM slot.
    always_comb begin
        exc_take     = 1'b0;
        exc_code     = 5'd0;
        bad_from_pc  = 1'b0;
        bad_from_alu = 1'b0;
        if (rst && MEM_Valid) begin
            exc_take = 1'b1;
            if (MEM_ExceptType[8] || int_pending_raw) begin
                exc_code = 5'd0;
            end else if (MEM_ExceptType[7]) begin
                exc_code    = 5'd4;
                bad_from_pc = 1'b1;
            end else if (MEM_ExceptType[6]) begin
                exc_code = 5'd10;
            end else if (MEM_ExceptType[5]) begin
                exc_code = 5'd12;
            end else if (MEM_ExceptType[4]) begin
                exc_code = 5'd8;
            end else if (MEM_ExceptType[3]) begin
                exc_code = 5'd9;
            end else if (MEM_ExceptType[0]) begin
                exc_code     = 5'd4;
                bad_from_alu = 1'b1;
            end else if (MEM_ExceptType[1]) begin
                exc_code     = 5'd5;
                bad_from_alu = 1'b1;
            end else begin
                exc_take = 1'b0;
            end
        end
    end

    assign eret_take    = rst & MEM_Valid & MEM_ExceptType[2] & ~exc_take;
    assign Exc_Flush    = exc_take | eret_take;
    assign Exc_Redirect = exc_take | eret_take;
    assign Exc_NPC      = exc_take  ? EXC_VECTOR :
                          eret_take ? epc_fwd    : 32'h0;

    // Free-running Count at half the clock rate and the Compare timer match.
    always_ff @(posedge clk) begin
        if (!rst) begin
            toggle_q  <= 1'b0;
            count_q   <= 32'h0;
            compare_q <= 32'h0;
            ti_q      <= 1'b0;
        end else begin
            toggle_q <= ~toggle_q;
            if (wr_count)
                count_q <= CP0_WrData;
            else if (toggle_q)
                count_q <= count_q + 32'd1;
            if (wr_compare) begin
                compare_q <= CP0_WrData;
                ti_q      <= 1'b0;
            end else if (count_q == compare_q) begin
                ti_q <= 1'b1;
            end
        end
    end

    // Status and Cause: MTC0 lands first, exception/ERET fields overwrite it.
    always_ff @(posedge clk) begin
        if (!rst) begin
            im_q       <= 8'h0;
            exl_q      <= 1'b0;
            ie_q       <= 1'b0;
            ip_hw_q    <= 6'h0;
            ip_sw_q    <= 2'h0;
            exc_code_q <= 5'h0;
            bd_q       <= 1'b0;
        end else begin
            ip_hw_q <= Ext_Int;
            if (wr_status) begin
                im_q  <= CP0_WrData[15:8];
                exl_q <= CP0_WrData[1];
                ie_q  <= CP0_WrData[0];
            end
            if (wr_cause)
                ip_sw_q <= CP0_WrData[9:8];
            if (exc_take) begin
                exl_q      <= 1'b1;
                exc_code_q <= exc_code;
                if (!exl_q)
                    bd_q <= MEM_IsInDelaySlot;
            end else if (eret_take) begin
                exl_q <= 1'b0;
            end
        end
    end

    // EPC captures the restart PC only when not already inside a handler.
    always_ff @(posedge clk) begin
        if (!rst) begin
            epc_q      <= 32'h0;
            badvaddr_q <= 32'h0;
        end else begin
            if (wr_epc)
                epc_q <= CP0_WrData;
            if (exc_take && !exl_q)
                epc_q <= MEM_IsInDelaySlot ? (MEM_PC - 32'd4) : MEM_PC;
            if (bad_from_pc)
                badvaddr_q <= MEM_PC;
            else if (bad_from_alu)
                badvaddr_q <= MEM_ALUOut;
        end
    end

endmodule

// File: tb/tb_cp0_exception_unit.sv
// Directed testbench for cp0_exception_unit with hand-computed expectations.
module tb_cp0_exception_unit;

    localparam logic [31:0] VEC = 32'hBFC0_0380;

    logic        clk;
    logic        rst;
    logic        MEM_Valid;
    logic [8:0]  MEM_ExceptType;
    logic [31:0] MEM_PC;
    logic [31:0] MEM_ALUOut;
    logic        MEM_IsInDelaySlot;
    logic [5:0]  Ext_Int;
    logic [4:0]  CP0_RdAddr;
    logic [2:0]  CP0_RdSel;
    logic [31:0] CP0_RdData;
    logic        CP0Wr;
    logic [4:0]  CP0_WrAddr;
    logic [2:0]  CP0_WrSel;
    logic [31:0] CP0_WrData;
    logic        Exc_Flush;
    logic        Exc_Redirect;
    logic [31:0] Exc_NPC;
    logic        Int_Pending;

    int vector_count = 0;
    int fail_count   = 0;
    logic [31:0] rd;

    cp0_exception_unit #(.EXC_VECTOR(VEC)) dut (
        .clk(clk), .rst(rst),
        .MEM_Valid(MEM_Valid), .MEM_ExceptType(MEM_ExceptType),
        .MEM_PC(MEM_PC), .MEM_ALUOut(MEM_ALUOut),
        .MEM_IsInDelaySlot(MEM_IsInDelaySlot), .Ext_Int(Ext_Int),
        .CP0_RdAddr(CP0_RdAddr), .CP0_RdSel(CP0_RdSel), .CP0_RdData(CP0_RdData),
        .CP0Wr(CP0Wr), .CP0_WrAddr(CP0_WrAddr), .CP0_WrSel(CP0_WrSel),
        .CP0_WrData(CP0_WrData),
        .Exc_Flush(Exc_Flush), .Exc_Redirect(Exc_Redirect), .Exc_NPC(Exc_NPC),
        .Int_Pending(Int_Pending)
    );

    // Free-running clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Safety net so the run can never hang.
    initial begin
        #200000;
        $display("[TB] FAIL timeout: got no finish, expected finish");
        $fatal(1, "[TB] timeout");
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vector_count++;
        if (got !== exp) begin
            fail_count++;
            $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic valid, input logic [8:0] etype,
                                 input logic [31:0] pc, input logic [31:0] alu,
                                 input logic ds);
        MEM_Valid         = valid;
        MEM_ExceptType    = etype;
        MEM_PC            = pc;
        MEM_ALUOut        = alu;
        MEM_IsInDelaySlot = ds;
    endtask

    task automatic mtc0(input logic [4:0] addr, input logic [31:0] data);
        CP0Wr      = 1'b1;
        CP0_WrAddr = addr;
        CP0_WrSel  = 3'd0;
        CP0_WrData = data;
        tick();
        CP0Wr      = 1'b0;
    endtask

    task automatic readReg(input logic [4:0] addr, input logic [2:0] sel, output logic [31:0] data);
        CP0_RdAddr = addr;
        CP0_RdSel  = sel;
        #1;
        data = CP0_RdData;
    endtask

    task automatic checkReg(input string tag, input logic [4:0] addr, input logic [31:0] exp);
        logic [31:0] d;
        readReg(addr, 3'd0, d);
        checkOutput(tag, d, exp);
    endtask

    // Directed scenario sequence.
    initial begin
        rst = 1'b0; CP0Wr = 1'b0; CP0_WrAddr = '0; CP0_WrSel = '0; CP0_WrData = '0;
        CP0_RdAddr = '0; CP0_RdSel = '0; Ext_Int = '0;
        applyStimulus(1'b0, 9'h0, 32'h0, 32'h0, 1'b0);
        tick();
        tick();

        // Reset state and reset gating of combinational outputs
        applyStimulus(1'b1, 9'h020, 32'h8000_1000, 32'h0, 1'b0);
        #1;
        checkOutput("rst_flush", Exc_Flush, 0);
        checkOutput("rst_npc", Exc_NPC, 0);
        checkOutput("rst_intp", Int_Pending, 0);
        checkReg("rst_status", 5'd12, 32'h0040_0000);
        checkReg("rst_cause", 5'd13, 32'h0);
        checkReg("rst_epc", 5'd14, 32'h0);
        checkReg("rst_count", 5'd9, 32'h0);
        checkReg("rst_compare", 5'd11, 32'h0);
        checkReg("rst_badv", 5'd8, 32'h0);
        checkReg("unimpl_addr", 5'd3, 32'h0);
        readReg(5'd12, 3'd1, rd);
        checkOutput("status_sel1", rd, 32'h0);

        // Overflow, not in delay slot
        rst = 1'b1;
        #1;
        checkOutput("ov_flush", Exc_Flush, 1);
        checkOutput("ov_redir", Exc_Redirect, 1);
        checkOutput("ov_npc", Exc_NPC, VEC);
        tick();
        applyStimulus(1'b0, 9'h0, 32'h0, 32'h0, 1'b0);
        checkReg("ov_epc", 5'd14, 32'h8000_1000);
        readReg(5'd13, 3'd0, rd);
        checkOutput("ov_code", rd[6:2], 12);
        checkReg("ov_status", 5'd12, 32'h0040_0002);

        // Syscall in delay slot, then Break while EXL is set
        mtc0(5'd12, 32'h0);
        applyStimulus(1'b1, 9'h010, 32'h8000_2004, 32'h0, 1'b1);
        tick();
        applyStimulus(1'b0, 9'h0, 32'h0, 32'h0, 1'b0);
        checkReg("sys_epc", 5'd14, 32'h8000_2000);
        readReg(5'd13, 3'd0, rd);
        checkOutput("sys_bd", rd[31], 1);
        checkOutput("sys_code", rd[6:2], 8);
        applyStimulus(1'b1, 9'h008, 32'h8000_5000, 32'h0, 1'b0);
        tick();
        applyStimulus(1'b0, 9'h0, 32'h0, 32'h0, 1'b0);
        checkReg("brk_epc_kept", 5'd14, 32'h8000_2000);
        readReg(5'd13, 3'd0, rd);
        checkOutput("brk_code", rd[6:2], 9);
        checkOutput("brk_bd_kept", rd[31], 1);

        // Data address errors and priority ordering
        applyStimulus(1'b1, 9'h001, 32'h8000_0100, 32'h0000_0003, 1'b0);
        tick();
        checkReg("rdadr_badv", 5'd8, 32'h3);
        readReg(5'd13, 3'd0, rd);
        checkOutput("rdadr_code", rd[6:2], 4);
        applyStimulus(1'b1, 9'h002, 32'h8000_0104, 32'h0000_0010, 1'b0);
        tick();
        checkReg("wradr_badv", 5'd8, 32'h10);
        readReg(5'd13, 3'd0, rd);
        checkOutput("wradr_code", rd[6:2], 5);
        applyStimulus(1'b1, 9'h041, 32'h8000_0108, 32'h0000_0044, 1'b0);
        tick();
        checkReg("ri_badv_kept", 5'd8, 32'h10);
        readReg(5'd13, 3'd0, rd);
        checkOutput("ri_over_rd", rd[6:2], 10);
        applyStimulus(1'b1, 9'h0A0, 32'h8000_0ABC, 32'h0, 1'b0);
        tick();
        checkReg("if_badv", 5'd8, 32'h8000_0ABC);
        readReg(5'd13, 3'd0, rd);
        checkOutput("if_over_ov", rd[6:2], 4);
        applyStimulus(1'b1, 9'h030, 32'h8000_0200, 32'h0, 1'b0);
        tick();
        applyStimulus(1'b0, 9'h0, 32'h0, 32'h0, 1'b0);
        readReg(5'd13, 3'd0, rd);
        checkOutput("ov_over_sys", rd[6:2], 12);

        // ERET returns to EPC and clears EXL
        mtc0(5'd14, 32'h8000_3000);
        applyStimulus(1'b1, 9'h004, 32'h8000_0300, 32'h0, 1'b0);
        #1;
        checkOutput("eret_npc", Exc_NPC, 32'h8000_3000);
        checkOutput("eret_flush", Exc_Flush, 1);
        tick();
        applyStimulus(1'b0, 9'h0, 32'h0, 32'h0, 1'b0);
        checkReg("eret_status", 5'd12, 32'h0040_0000);
        CP0Wr = 1'b1; CP0_WrAddr = 5'd14; CP0_WrSel = 3'd0; CP0_WrData = 32'h8000_4000;
        applyStimulus(1'b1, 9'h004, 32'h8000_0304, 32'h0, 1'b0);
        #1;
        checkOutput("eret_fwd_npc", Exc_NPC, 32'h8000_4000);
        tick();
        CP0Wr = 1'b0;
        applyStimulus(1'b0, 9'h0, 32'h0, 32'h0, 1'b0);
        checkReg("eret_fwd_epc", 5'd14, 32'h8000_4000);

        // Bubble in MEM is ignored; idle outputs are zero
        applyStimulus(1'b0, 9'h020, 32'h8000_0400, 32'h0, 1'b0);
        #1;
        checkOutput("bubble_flush", Exc_Flush, 0);
        checkOutput("bubble_npc", Exc_NPC, 0);
        applyStimulus(1'b0, 9'h0, 32'h0, 32'h0, 1'b0);

        // External interrupt through IM2
        mtc0(5'd12, 32'h0000_0401);
        #1;
        checkOutput("int_before", Int_Pending, 0);
        Ext_Int = 6'h01;
        tick();
        checkOutput("int_pending", Int_Pending, 1);
        checkOutput("int_nvalid_flush", Exc_Flush, 0);
        applyStimulus(1'b1, 9'h000, 32'h8000_6000, 32'h0, 1'b0);
        #1;
        checkOutput("int_flush", Exc_Flush, 1);
        checkOutput("int_npc", Exc_NPC, VEC);
        tick();
        applyStimulus(1'b0, 9'h0, 32'h0, 32'h0, 1'b0);
        Ext_Int = 6'h00;
        readReg(5'd13, 3'd0, rd);
        checkOutput("int_code", rd[6:2], 0);
        checkReg("int_epc", 5'd14, 32'h8000_6000);
        checkReg("int_status", 5'd12, 32'h0040_0403);
        checkOutput("int_masked_exl", Int_Pending, 0);

        // Reset asserted while an exception is presented
        applyStimulus(1'b1, 9'h020, 32'h8000_7000, 32'h0, 1'b0);
        rst = 1'b0;
        #1;
        checkOutput("rstx_flush", Exc_Flush, 0);
        checkOutput("rstx_npc", Exc_NPC, 0);
        tick();
        applyStimulus(1'b0, 9'h0, 32'h0, 32'h0, 1'b0);
        checkReg("rstx_status", 5'd12, 32'h0040_0000);
        checkReg("rstx_cause", 5'd13, 32'h0);
        checkReg("rstx_epc", 5'd14, 32'h0);
        checkReg("rstx_badv", 5'd8, 32'h0);

        // Timer: Compare=10 from Count=0, TI after 20 more edges
        rst = 1'b1;
        mtc0(5'd11, 32'd10);
        repeat (19) tick();
        checkReg("tmr_count10", 5'd9, 32'd10);
        readReg(5'd13, 3'd0, rd);
        checkOutput("tmr_ti_early", rd[30], 0);
        tick();
        readReg(5'd13, 3'd0, rd);
        checkOutput("tmr_ti_set", rd[30], 1);
        checkOutput("tmr_ip7", rd[15], 1);
        mtc0(5'd11, 32'd100);
        readReg(5'd13, 3'd0, rd);
        checkOutput("tmr_ti_clr", rd[30], 0);
        checkReg("tmr_count11", 5'd9, 32'd11);
        mtc0(5'd9, 32'hFFFF_FFFF);
        checkReg("cnt_max", 5'd9, 32'hFFFF_FFFF);
        tick();
        checkReg("cnt_wrap", 5'd9, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vector_count, fail_count);
        $finish;
    end

endmodule
